cache_refill: RTL and testbench
===============================

Name: cache_refill

Overview:
Miss-handling stage directly downstream of cache_ctrl.
- Accepts one line-miss request at a time and issues a line-aligned read to backing memory.
- Collects 4 beats of 32-bit data and writes them into the selected way's data array.
- Then writes the tag and valid bit, and pulses completion so cache_ctrl can replay the missed read.
- Addresses are word-addressed: a line is 4 words, offset is addr[1:0].

Parameters:
- ADDR_W, 32, word-address width.
- NUM_SETS, 64, sets per way; IDX_W = $clog2(NUM_SETS).
- NUM_WAYS, 4, associativity; WAY_W = $clog2(NUM_WAYS).
- MEM_TIMEOUT, 255, cycles to wait for a memory beat before flagging an error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- miss_vld  in  1  miss request valid
- miss_rdy  out  1  refill unit can accept a miss
- miss_addr  in  ADDR_W  full word address of the missing access
- miss_way  in  WAY_W  victim way chosen by cache_ctrl
- mem_req_vld  out  1  memory line-read request valid
- mem_req_rdy  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  line-aligned address (addr[1:0]=0)
- mem_resp_vld  in  1  memory data beat valid (always accepted, no backpressure)
- mem_resp_data  in  32  beat data, beat k = word k
- dat_we  out  1  data-array write strobe
- dat_way  out  WAY_W  data write way
- dat_idx  out  IDX_W  data write set index
- dat_word  out  2  word within line
- dat_wdata  out  32  data written
- tag_we  out  1  tag/valid write strobe
- tag_way  out  WAY_W  tag write way
- tag_idx  out  IDX_W  tag write set index
- tag_wdata  out  ADDR_W-IDX_W-2  tag = addr[ADDR_W-1:IDX_W+2]
- fill_done  out  1  one-cycle pulse when the line is installed
- fill_err  out  1  one-cycle pulse on memory timeout; line is not installed
- busy  out  1  high in every state except IDLE

Behaviour:
Reset values (rst_n low, asynchronous): all outputs 0; miss_rdy = 1; state = IDLE; beat counter = 0; timeout counter = 0.

State machine: IDLE -> REQ -> FILL -> TAG -> IDLE.
- IDLE:
  - miss_rdy = 1.
  - On miss_vld && miss_rdy, latch addr and way; next state REQ.
  - miss_rdy is 0 in every other state.
- REQ:
  - mem_req_vld = 1; mem_req_addr = {latched addr[ADDR_W-1:2], 2'b00}; held stable until mem_req_rdy.
  - On handshake, next state FILL; clear beat counter.
- FILL:
  - Each mem_resp_vld cycle drives the data-array write combinationally: dat_we = 1, dat_word = beat counter, dat_wdata = mem_resp_data, dat_idx/dat_way from the latched request.
  - Beat counter increments, 2-bit wrap.
  - On the 4th beat (counter == 3 && mem_resp_vld), next state TAG.
- TAG:
  - Single cycle: tag_we = 1 with latched way/idx/tag.
  - fill_done is registered, so it pulses 1 in the cycle after TAG.
  - Next state IDLE.

Timing:
- Minimum miss handshake to fill_done: 7 cycles, with mem_req_rdy and 4 consecutive beats immediately available.
- A new miss is accepted in the same cycle fill_done pulses, since the FSM is already in IDLE.

Boundary conditions:
- Timeout:
  - The timeout counter runs in REQ and FILL and resets on every mem_req handshake or beat.
  - If it reaches MEM_TIMEOUT (MEM_TIMEOUT != 0), the FSM returns to IDLE, pulses fill_err, and issues no tag_we.
  - Already-written data words are harmless because valid is not set.
- mem_resp_vld in IDLE, REQ or TAG is ignored: no writes, counter unchanged.
- mem_resp_vld held for more than 4 cycles: beats after the 4th are ignored.
- miss_vld while busy: stalls via miss_rdy = 0; the request must be held stable by the sender.
- Reset mid-fill: immediate return to IDLE; any partially written line stays invalid because tag_we never fired.

Optional Feature:
Macro CACHE_REFILL_CWF_EN enables critical-word-first operation.
- When defined:
  - mem_req_addr carries the full miss_addr; memory returns beats starting at word miss_addr[1:0] and wrapping.
  - The beat counter starts at miss_addr[1:0] and dat_word follows it; completion still occurs after 4 beats.
  - Extra ports: cwf_vld out 1 and cwf_data out 32, pulsed on the first beat only, so cache_ctrl can answer early.
- When undefined: line-aligned request, beats in order 0..3, no cwf ports.

Decomposition:
- Package cache_pkg holds:
  - LINE_WORDS = 4 and OFFSET_W = 2.
  - typedef refill_state_e {IDLE, REQ, FILL, TAG}.
  - typedef miss_req_t {addr, way}.
  - function tag_of(addr) and function idx_of(addr), shared with cache_ctrl.
- No sub-module needed; the timeout counter stays inline.

Test Plan:
- Basic fill: miss 0x0FF001F2 way 1, mem_req_rdy = 1, beats FF0000FF, F0F0F0F0, 00FFFF00, 00FF00FF back-to-back -> mem_req_addr 0x0FF001F0; dat writes to idx 0x3C way 1, words 0..3 in order; tag_we with tag 0x0FF001; fill_done exactly 7 cycles after the miss handshake.
- Gapped beats and stalled request: mem_req_rdy low for 3 cycles, 2-cycle gaps between beats -> mem_req_addr stable while stalled; exactly 4 dat_we pulses; single fill_done.
- Back-to-back misses: second miss (0x0AA001F0, way 2) held during the first fill -> miss_rdy = 0 until the first fill_done cycle; second request accepted in that cycle.
- Timeout: MEM_TIMEOUT = 8, only 2 beats delivered -> fill_err pulse; no tag_we; busy = 0; next miss accepted normally.
- Reset mid-fill: rst_n asserted after beat 2 -> all outputs 0 immediately; no tag_we after release.
- CWF (macro defined): miss 0x000001F2 -> mem_req_addr 0x000001F2; dat_word sequence 2,3,0,1; cwf_vld with the first beat's data; tag 0x000001.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and address helpers for cache_ctrl / cache_refill.
//   LINE_WORDS, OFFSET_W : line geometry (4 words, 2-bit word offset)
//   refill_state_e       : refill FSM encoding
//   miss_req_t           : miss request record passed from cache_ctrl
//   tag_of / idx_of      : split a word address for a given index width
package cache_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned OFFSET_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    TAG
  } refill_state_e;

  // Sized generously so any configured cache can carry its request in it.
  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  way;
  } miss_req_t;

  function automatic logic [63:0] tag_of(input logic [63:0] addr,
                                         input int unsigned idx_w);
    return addr >> (idx_w + OFFSET_W);
  endfunction

  function automatic logic [63:0] idx_of(input logic [63:0] addr,
                                         input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return (addr >> OFFSET_W) & mask;
  endfunction

endpackage

// File: rtl/cache_refill.sv
// cache_refill: miss-handling stage downstream of cache_ctrl.
// Accepts one line miss, reads the line from memory (4 beats), writes the
// data array, then the tag/valid entry, and pulses fill_done. A stalled
// memory (MEM_TIMEOUT cycles without progress, 0 = never) aborts with
// fill_err and leaves the line invalid.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   miss_vld/miss_rdy/miss_addr/miss_way   miss request handshake
//   mem_req_vld/mem_req_rdy/mem_req_addr   memory line-read request
//   mem_resp_vld/mem_resp_data      memory beats (no backpressure)
//   dat_we/dat_way/dat_idx/dat_word/dat_wdata   data-array write
//   tag_we/tag_way/tag_idx/tag_wdata            tag/valid write
//   fill_done, fill_err             registered one-cycle completion pulses
//   busy                            FSM not in IDLE
// Build option: define CACHE_REFILL_CWF_EN for critical-word-first refill
// (full miss address sent to memory, beats wrap from the missed word, and
// cwf_vld/cwf_data present the first beat to cache_ctrl).
module cache_refill
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_SETS    = 64,
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned MEM_TIMEOUT = 255,
  localparam int unsigned IDX_W      = $clog2(NUM_SETS),
  localparam int unsigned WAY_W      = $clog2(NUM_WAYS),
  localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFFSET_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_vld,
  output logic              miss_rdy,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic [WAY_W-1:0]  miss_way,
  output logic              mem_req_vld,
  input  logic              mem_req_rdy,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_vld,
  input  logic [31:0]       mem_resp_data,
  output logic              dat_we,
  output logic [WAY_W-1:0]  dat_way,
  output logic [IDX_W-1:0]  dat_idx,
  output logic [1:0]        dat_word,
  output logic [31:0]       dat_wdata,
  output logic              tag_we,
  output logic [WAY_W-1:0]  tag_way,
  output logic [IDX_W-1:0]  tag_idx,
  output logic [TAG_W-1:0]  tag_wdata,
  output logic              fill_done,
  output logic              fill_err,
  output logic              busy
`ifdef CACHE_REFILL_CWF_EN
  ,
  output logic              cwf_vld,
  output logic [31:0]       cwf_data
`endif
);

  localparam int unsigned TMO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  refill_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WAY_W-1:0]  way_q;
  logic [1:0]        beat_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              done_d, err_d;
  logic              tmo_hit, progress;
  logic [1:0]        start_word, last_word;
  logic [ADDR_W-1:0] req_addr;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  assign idx = IDX_W'(idx_of(64'(addr_q), IDX_W));
  assign tag = TAG_W'(tag_of(64'(addr_q), IDX_W));

`ifdef CACHE_REFILL_CWF_EN
  assign start_word = addr_q[1:0];
  assign req_addr   = addr_q;
`else
  assign start_word = 2'b00;
  assign req_addr   = {addr_q[ADDR_W-1:2], 2'b00};
`endif
  // The fourth beat is the one just before the start word (mod 4).
  assign last_word = start_word - 2'd1;

  assign tmo_hit  = (MEM_TIMEOUT != 0) && (tmo_q == TMO_W'(MEM_TIMEOUT));
  assign progress = ((state_q == REQ) && mem_req_rdy) ||
                    ((state_q == FILL) && mem_resp_vld);

  always_comb begin
    state_d      = state_q;
    miss_rdy     = 1'b0;
    mem_req_vld  = 1'b0;
    mem_req_addr = '0;
    dat_we       = 1'b0;
    dat_way      = '0;
    dat_idx      = '0;
    dat_word     = '0;
    dat_wdata    = '0;
    tag_we       = 1'b0;
    tag_way      = '0;
    tag_idx      = '0;
    tag_wdata    = '0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    busy         = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        miss_rdy = 1'b1;
        if (miss_vld) state_d = REQ;
      end
      REQ: begin
        mem_req_vld  = 1'b1;
        mem_req_addr = req_addr;
        if (mem_req_rdy) begin
          state_d = FILL;
        end else if (tmo_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      FILL: begin
        if (mem_resp_vld) begin
          dat_we    = 1'b1;
          dat_way   = way_q;
          dat_idx   = idx;
          dat_word  = beat_q;
          dat_wdata = mem_resp_data;
          if (beat_q == last_word) state_d = TAG;
        end else if (tmo_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      TAG: begin
        tag_we    = 1'b1;
        tag_way   = way_q;
        tag_idx   = idx;
        tag_wdata = tag;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_REFILL_CWF_EN
  // Only the first beat of a fill lands on the start word.
  assign cwf_vld  = dat_we && (beat_q == start_word);
  assign cwf_data = cwf_vld ? mem_resp_data : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      way_q     <= '0;
      beat_q    <= '0;
      tmo_q     <= '0;
      fill_done <= 1'b0;
      fill_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_done <= done_d;
      fill_err  <= err_d;
      if ((state_q == IDLE) && miss_vld) begin
        addr_q <= miss_addr;
        way_q  <= miss_way;
      end
      if ((state_q == REQ) && mem_req_rdy) begin
        beat_q <= start_word;
      end else if ((state_q == FILL) && mem_resp_vld) begin
        beat_q <= beat_q + 2'd1;
      end
      if ((state_q == REQ) || (state_q == FILL)) begin
        if (progress || tmo_hit) tmo_q <= '0;
        else                     tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
module tb_cache_refill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_vld = 1'b0;
  logic        miss_rdy;
  logic [31:0] miss_addr = '0;
  logic [1:0]  miss_way = '0;
  logic        mem_req_vld;
  logic        mem_req_rdy = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_vld = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        dat_we;
  logic [1:0]  dat_way;
  logic [5:0]  dat_idx;
  logic [1:0]  dat_word;
  logic [31:0] dat_wdata;
  logic        tag_we;
  logic [1:0]  tag_way;
  logic [5:0]  tag_idx;
  logic [23:0] tag_wdata;
  logic        fill_done;
  logic        fill_err;
  logic        busy;
`ifdef CACHE_REFILL_CWF_EN
  logic        cwf_vld;
  logic [31:0] cwf_data;
`endif

  cache_refill #(.ADDR_W(32), .NUM_SETS(64), .NUM_WAYS(4), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_vld(miss_vld), .miss_rdy(miss_rdy), .miss_addr(miss_addr), .miss_way(miss_way),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_resp_vld(mem_resp_vld), .mem_resp_data(mem_resp_data),
    .dat_we(dat_we), .dat_way(dat_way), .dat_idx(dat_idx), .dat_word(dat_word),
    .dat_wdata(dat_wdata),
    .tag_we(tag_we), .tag_way(tag_way), .tag_idx(tag_idx), .tag_wdata(tag_wdata),
    .fill_done(fill_done), .fill_err(fill_err), .busy(busy)
`ifdef CACHE_REFILL_CWF_EN
    , .cwf_vld(cwf_vld), .cwf_data(cwf_data)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  int hs_cyc = 0;
  int done_cyc = -1;
  int n_dat = 0, n_tag = 0, n_done = 0, n_err = 0;

  logic [63:0] exp_req[$];
  logic [63:0] exp_dat[$];
  logic [63:0] exp_tag[$];
  logic [63:0] exp_cwf[$];
  byte         exp_evt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin : mon
    logic [63:0] e;
    byte ev;
    if (rst_n) begin
      if (mem_req_vld && mem_req_rdy) begin
        if (exp_req.size() == 0) unexp("mem_req");
        else begin e = exp_req.pop_front(); chk("mem_req_addr", 64'(mem_req_addr), e); end
      end
      if (dat_we) begin
        n_dat++;
        if (exp_dat.size() == 0) unexp("dat_we");
        else begin
          e = exp_dat.pop_front();
          chk("dat_write", {22'd0, dat_way, dat_idx, dat_word, dat_wdata}, e);
        end
      end
      if (tag_we) begin
        n_tag++;
        if (exp_tag.size() == 0) unexp("tag_we");
        else begin e = exp_tag.pop_front(); chk("tag_write", {32'd0, tag_way, tag_idx, tag_wdata}, e); end
      end
      if (fill_done || fill_err) begin
        if (fill_done) begin n_done++; done_cyc = cyc; end
        if (fill_err) n_err++;
        if (exp_evt.size() == 0) unexp("completion");
        else begin
          ev = exp_evt.pop_front();
          chk("completion_kind", 64'({fill_done, fill_err}), (ev == "D") ? 64'd2 : 64'd1);
        end
      end
      if (miss_vld && busy && miss_rdy) unexp("miss_rdy_while_busy");
`ifdef CACHE_REFILL_CWF_EN
      if (cwf_vld) begin
        if (exp_cwf.size() == 0) unexp("cwf_vld");
        else begin e = exp_cwf.pop_front(); chk("cwf_data", 64'(cwf_data), e); end
      end
`endif
    end
  end

  // Expected line traffic; idx/tag are hand-computed by the caller.
  task automatic push_line(input logic [31:0] a, input logic [1:0] w, input logic [5:0] idx,
                           input logic [23:0] tag, input logic [127:0] dv, input int nw,
                           input byte evt, output logic [31:0] req);
    logic [1:0] st;
`ifdef CACHE_REFILL_CWF_EN
    st  = a[1:0];
    req = a;
    exp_cwf.push_back(64'(dv[31:0]));
`else
    st  = 2'b00;
    req = {a[31:2], 2'b00};
`endif
    exp_req.push_back(64'(req));
    for (int b = 0; b < nw; b++)
      exp_dat.push_back({22'd0, w, idx, st + 2'(b), dv[b*32 +: 32]});
    if (evt == "D") exp_tag.push_back({32'd0, w, idx, tag});
    if (evt != 0) exp_evt.push_back(evt);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic issue_miss(input logic [31:0] a, input logic [1:0] w);
    int n;
    n = 0;
    miss_vld = 1'b1; miss_addr = a; miss_way = w;
    @(negedge clk);
    while (!miss_rdy && n < 60) begin @(negedge clk); n++; end
    if (!miss_rdy) begin
      unexp("miss_accept_timeout");
      miss_vld = 1'b0;
      return;
    end
    hs_cyc = cyc;
    @(posedge clk); #1;
    miss_vld = 1'b0;
  endtask

  // Memory side: stall the request, then deliver beats with gaps.
  task automatic serve(input int stall, input int gap, input int nbeats,
                       input logic [127:0] dv, input logic [31:0] req);
    for (int s = 0; s < stall; s++) begin
      mem_resp_vld = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("req_stable", {31'd0, mem_req_vld, mem_req_addr}, {31'd0, 1'b1, req});
      @(posedge clk); #1;
    end
    mem_resp_vld = 1'b0;
    mem_req_rdy  = 1'b1;
    @(posedge clk); #1;
    mem_req_rdy = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      mem_resp_vld  = 1'b1;
      mem_resp_data = (b < 4) ? dv[b*32 +: 32] : (32'hBAD0_0000 | 32'(b));
      @(posedge clk); #1;
      mem_resp_vld = 1'b0;
      for (int g = 0; g < gap && b < nbeats - 1; g++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] req, req2;
    int d0, t0, e0, dn0, n;

    // Reset state
    #12;
    chk("reset_flags", 64'({miss_rdy, busy, mem_req_vld, dat_we, tag_we, fill_done, fill_err}),
        64'b1000000);
    chk("reset_req_addr", 64'(mem_req_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Beats while idle are ignored
    mem_resp_vld = 1'b1; mem_resp_data = 32'h1234_5678;
    @(negedge clk);
    chk("idle_beat_ignored", 64'({dat_we, busy}), 0);
    cycles(3);
    mem_resp_vld = 1'b0;

    // Basic fill with minimum latency
    push_line(32'h0FF0_01F2, 2'd1, 6'h3C, 24'h0FF001,
              {32'h00FF00FF, 32'h00FFFF00, 32'hF0F0F0F0, 32'hFF0000FF}, 4, "D", req);
    done_cyc = -1;
    issue_miss(32'h0FF0_01F2, 2'd1);
    serve(0, 0, 4, {32'h00FF00FF, 32'h00FFFF00, 32'hF0F0F0F0, 32'hFF0000FF}, req);
    cycles(2);
    chk("basic_latency", 64'(done_cyc - hs_cyc), 7);

    // Stalled request, gapped beats, beats in REQ ignored
    d0 = n_dat; dn0 = n_done;
    push_line(32'h1234_5678, 2'd3, 6'h1E, 24'h123456,
              {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1}, 4, "D", req);
    issue_miss(32'h1234_5678, 2'd3);
    serve(3, 2, 4, {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1}, req);
    cycles(4);
    chk("gapped_dat_count", 64'(n_dat - d0), 4);
    chk("gapped_done_count", 64'(n_done - dn0), 1);

    // Back-to-back misses: second held during first fill
    push_line(32'h0000_0ABD, 2'd0, 6'h2F, 24'h00000A,
              {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4, "D", req);
    push_line(32'h0AA0_01F0, 2'd2, 6'h3C, 24'h0AA001,
              {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555}, 4, "D", req2);
    issue_miss(32'h0000_0ABD, 2'd0);
    miss_vld = 1'b1; miss_addr = 32'h0AA0_01F0; miss_way = 2'd2;
    serve(0, 0, 4, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, req);
    @(negedge clk);
    chk("b2b_rdy_in_tag", 64'(miss_rdy), 0);
    done_cyc = -1;
    issue_miss(32'h0AA0_01F0, 2'd2);
    chk("b2b_accept_on_done", 64'(hs_cyc), 64'(done_cyc));
    serve(0, 0, 4, {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555}, req2);
    cycles(3);

    // Timeout after 2 beats, then recovery with extra beats
    t0 = n_tag; e0 = n_err;
    push_line(32'h0000_0040, 2'd1, 6'h10, 24'h000000,
              {32'h0, 32'h0, 32'hC2C2C2C2, 32'hC1C1C1C1}, 2, "E", req);
    issue_miss(32'h0000_0040, 2'd1);
    serve(0, 0, 2, {32'h0, 32'h0, 32'hC2C2C2C2, 32'hC1C1C1C1}, req);
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin @(negedge clk); n++; end
    chk("tmo_busy", 64'(busy), 0);
    cycles(2);
    chk("tmo_err_count", 64'(n_err - e0), 1);
    chk("tmo_no_tag", 64'(n_tag - t0), 0);
    d0 = n_dat;
    push_line(32'hFFFF_FFFF, 2'd3, 6'h3F, 24'hFFFFFF,
              {32'hD4D4D4D4, 32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1}, 4, "D", req);
    issue_miss(32'hFFFF_FFFF, 2'd3);
    serve(0, 0, 6, {32'hD4D4D4D4, 32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1}, req);
    cycles(3);
    chk("extra_beats_dat_count", 64'(n_dat - d0), 4);

    // Reset mid-fill
    t0 = n_tag;
    push_line(32'h0000_0100, 2'd2, 6'h00, 24'h000001,
              {32'h0, 32'h0, 32'hE2E2E2E2, 32'hE1E1E1E1}, 2, 0, req);
    issue_miss(32'h0000_0100, 2'd2);
    serve(0, 0, 2, {32'h0, 32'h0, 32'hE2E2E2E2, 32'hE1E1E1E1}, req);
    mem_resp_vld = 1'b1; mem_resp_data = 32'hE3E3E3E3;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_flags",
        64'({miss_rdy, busy, mem_req_vld, dat_we, tag_we, fill_done, fill_err}), 64'b1000000);
    chk("rst_mid_dat_word", 64'({dat_word, dat_wdata}), 0);
    @(posedge clk); #1;
    mem_resp_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(8);
    chk("rst_mid_no_tag", 64'(n_tag - t0), 0);

`ifdef CACHE_REFILL_CWF_EN
    // Critical word first: words 2,3,0,1
    push_line(32'h0000_01F2, 2'd0, 6'h3C, 24'h000001,
              {32'hF4F4F4F4, 32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1}, 4, "D", req);
    issue_miss(32'h0000_01F2, 2'd0);
    serve(0, 0, 4, {32'hF4F4F4F4, 32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1}, req);
    cycles(3);
`endif

    cycles(3);
    chk("scoreboard_drained",
        64'(exp_req.size() + exp_dat.size() + exp_tag.size() + exp_evt.size() + exp_cwf.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
